// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (always wins) and a
// buffered long-latency unit, with starvation stall and pending-register scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  WB_Valid,
  input  logic [ADDR_WIDTH-1:0] WB_Reg,
  input  logic [DATA_WIDTH-1:0] WB_Data,
  input  logic                  LU_Valid,
  output logic                  LU_Ready,
  input  logic [ADDR_WIDTH-1:0] LU_Reg,
  input  logic [DATA_WIDTH-1:0] LU_Data,
  input  logic                  Issue_Valid,
  input  logic [ADDR_WIDTH-1:0] Issue_Reg,
  input  logic [ADDR_WIDTH-1:0] Read_Reg_1,
  input  logic [ADDR_WIDTH-1:0] Read_Reg_2,
  output logic                  Hazard_1,
  output logic                  Hazard_2,
  output logic                  Stall_Req,
  output logic                  Register_Write,
  output logic [ADDR_WIDTH-1:0] Write_Reg,
  output logic [DATA_WIDTH-1:0] Register_Write_Data,
  output logic                  Dbg_State
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int REGS   = 1 << ADDR_WIDTH;

  typedef enum logic {NORMAL = 1'b0, STARVED = 1'b1} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] fifo_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic [WAIT_W-1:0]     wait_cnt, wait_next;
  logic [REGS-1:0]       pending, pending_next;
  logic                  fifo_empty, push, pop, any_grant;
  logic [ADDR_WIDTH-1:0] head_reg;

  // LU handshake: a result transfers on a posedge where LU_Valid && LU_Ready;
  // the LU holds LU_Reg/LU_Data stable until then. LU_Ready is combinational.
  assign fifo_empty = (count == '0);
  assign LU_Ready   = (count < CNT_W'(FIFO_DEPTH));
  assign push       = LU_Valid && LU_Ready;
  assign pop        = !WB_Valid && !fifo_empty;
  assign head_reg   = fifo_reg[rd_ptr];
  assign Stall_Req  = (state == STARVED);
  assign Dbg_State  = state;
  assign Hazard_1   = pending[Read_Reg_1];
  assign Hazard_2   = pending[Read_Reg_2];

  always_comb begin
    any_grant           = 1'b0;
    Write_Reg           = '0;
    Register_Write_Data = '0;
    if (WB_Valid) begin
      any_grant           = 1'b1;
      Write_Reg           = WB_Reg;
      Register_Write_Data = WB_Data;
    end else if (!fifo_empty) begin
      any_grant           = 1'b1;
      Write_Reg           = head_reg;
      Register_Write_Data = fifo_data[rd_ptr];
    end
    // Register 0 is hardwired; still pop a reg-0 head, just suppress the write.
    Register_Write = Reset_n && any_grant && (Write_Reg != '0);
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase

    wait_next = wait_cnt;
    if (pop)
      wait_next = '0;
    else if (!fifo_empty && wait_cnt != WAIT_W'(STARVE_LIMIT))
      wait_next = wait_cnt + WAIT_W'(1);

    pending_next = pending;
    if (pop)
      pending_next[head_reg] = 1'b0;
    if (Issue_Valid && Issue_Reg != '0)
      pending_next[Issue_Reg] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (wait_next == WAIT_W'(STARVE_LIMIT)) state_next = STARVED;
      STARVED: if (pop) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= NORMAL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      pending  <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      wait_cnt <= wait_next;
      pending  <= pending_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= LU_Reg;
      fifo_data[wr_ptr] <= LU_Data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-based reference
// model of the write-port sharing, starvation stall and scoreboard rules.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          Clk, Reset_n;
  logic          WB_Valid, LU_Valid, LU_Ready, Issue_Valid;
  logic [AW-1:0] WB_Reg, LU_Reg, Issue_Reg, Read_Reg_1, Read_Reg_2, Write_Reg;
  logic [DW-1:0] WB_Data, LU_Data, Register_Write_Data;
  logic          Hazard_1, Hazard_2, Stall_Req, Register_Write, Dbg_State;

  regfile_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .WB_Valid(WB_Valid), .WB_Reg(WB_Reg), .WB_Data(WB_Data),
    .LU_Valid(LU_Valid), .LU_Ready(LU_Ready), .LU_Reg(LU_Reg), .LU_Data(LU_Data),
    .Issue_Valid(Issue_Valid), .Issue_Reg(Issue_Reg),
    .Read_Reg_1(Read_Reg_1), .Read_Reg_2(Read_Reg_2),
    .Hazard_1(Hazard_1), .Hazard_2(Hazard_2), .Stall_Req(Stall_Req),
    .Register_Write(Register_Write), .Write_Reg(Write_Reg),
    .Register_Write_Data(Register_Write_Data), .Dbg_State(Dbg_State)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: ordered queue of {reg,data}, cycles the head has waited, pending set
  logic [AW+DW-1:0] exp_q[$];
  int  head_wait;
  bit  m_pending[32];
  bit  lu_hold;

  task automatic model_reset();
    exp_q.delete();
    head_wait = 0;
    lu_hold   = 1'b0;
    for (int r = 0; r < 32; r++) m_pending[r] = 1'b0;
  endtask

  task automatic compare_all();
    logic          e_rw;
    logic [AW-1:0] e_reg;
    logic [DW-1:0] e_data;
    e_reg  = '0;
    e_data = '0;
    if (WB_Valid) begin
      e_reg  = WB_Reg;
      e_data = WB_Data;
    end else if (exp_q.size() > 0) begin
      e_reg  = exp_q[0][AW+DW-1:DW];
      e_data = exp_q[0][DW-1:0];
    end
    e_rw = (WB_Valid || exp_q.size() > 0) && (e_reg != 0);
    check_eq("register_write", 64'(Register_Write), 64'(e_rw));
    check_eq("write_reg", 64'(Write_Reg), 64'(e_reg));
    check_eq("write_data", 64'(Register_Write_Data), 64'(e_data));
    check_eq("lu_ready", 64'(LU_Ready), 64'(exp_q.size() < DEPTH));
    check_eq("stall_req", 64'(Stall_Req), 64'(head_wait >= LIMIT));
    check_eq("hazard_1", 64'(Hazard_1), 64'(m_pending[Read_Reg_1]));
    check_eq("hazard_2", 64'(Hazard_2), 64'(m_pending[Read_Reg_2]));
  endtask

  // apply one posedge's worth of rules to the model, using the inputs just sampled
  task automatic model_edge();
    int  size_before;
    bit  did_pop;
    size_before = exp_q.size();
    did_pop = !WB_Valid && size_before > 0;
    if (did_pop) begin
      m_pending[exp_q[0][AW+DW-1:DW]] = 1'b0;
      void'(exp_q.pop_front());
      head_wait = 0;
    end else if (size_before > 0) begin
      head_wait++;
    end
    if (Issue_Valid && Issue_Reg != 0) m_pending[Issue_Reg] = 1'b1;
    if (LU_Valid && size_before < DEPTH) begin
      exp_q.push_back({LU_Reg, LU_Data});
      lu_hold = 1'b0;
    end
  endtask

  // driver: inputs change on negedge, outputs compared 1ns later, model steps on posedge
  task automatic run_cycles(input int n, input int wb_pct, input int lu_pct, input int iss_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      WB_Valid = ($urandom_range(0, 99) < wb_pct);
      WB_Reg   = AW'($urandom_range(0, 7));
      WB_Data  = $urandom;
      if (!lu_hold && $urandom_range(0, 99) < lu_pct) begin
        lu_hold = 1'b1;
        LU_Reg  = AW'($urandom_range(0, 7));
        LU_Data = $urandom;
      end
      LU_Valid    = lu_hold;
      Issue_Valid = ($urandom_range(0, 99) < iss_pct);
      Issue_Reg   = AW'($urandom_range(0, 7));
      Read_Reg_1  = AW'($urandom_range(0, 7));
      Read_Reg_2  = AW'($urandom_range(0, 7));
      #1 compare_all();
      @(posedge Clk);
      model_edge();
    end
  endtask

  task automatic idle_inputs();
    WB_Valid = 0; WB_Reg = '0; WB_Data = '0;
    LU_Valid = 0; LU_Reg = '0; LU_Data = '0;
    Issue_Valid = 0; Issue_Reg = '0;
    Read_Reg_1 = '0; Read_Reg_2 = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_register_write"}, 64'(Register_Write), 64'(0));
    check_eq({tag, "_stall_req"}, 64'(Stall_Req), 64'(0));
    check_eq({tag, "_hazard_1"}, 64'(Hazard_1), 64'(0));
    check_eq({tag, "_hazard_2"}, 64'(Hazard_2), 64'(0));
  endtask

  initial begin
    Reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    #1 check_eq("lu_ready_after_reset", 64'(LU_Ready), 64'(1));

    // directed writeback pass-through
    @(negedge Clk);
    WB_Valid = 1; WB_Reg = 5; WB_Data = 32'hDEADBEEF;
    #1;
    check_eq("wb_direct_rw", 64'(Register_Write), 64'(1));
    check_eq("wb_direct_reg", 64'(Write_Reg), 64'(5));
    check_eq("wb_direct_data", 64'(Register_Write_Data), 64'hDEADBEEF);
    @(posedge Clk);
    model_edge();

    run_cycles(800, 30, 40, 30);   // mixed traffic
    run_cycles(400, 95, 60, 30);   // writeback-heavy, forces starvation
    run_cycles(400, 60, 80, 50);
    run_cycles(300, 10, 70, 40);   // drain-dominant

    // build up backlog, then reset mid-cycle with WB requesting
    run_cycles(20, 100, 100, 80);
    @(negedge Clk);
    WB_Valid = 1; WB_Reg = 3; Read_Reg_1 = 7; Read_Reg_2 = 6;
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    check_eq("midreset_lu_ready", 64'(LU_Ready), 64'(1));
    idle_inputs();
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 check_eq("post_midreset_lu_ready", 64'(LU_Ready), 64'(1));

    run_cycles(600, 50, 50, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
